ifetch_responder: RTL and testbench

- Responder end of the per-core instruction fetch interface.
- Accepts fetch requests (warp id + PC) from the warp fetch stage and reads a word-addressed instruction SRAM.
- Returns instructions in request order through a response FIFO, with a per-warp flush for branch redirects.
- Instruction SRAM contents are loaded through a separate write port driven by the loader/host.

---
 rtl/ifetch_responder_pkg.sv | 34 +++
 rtl/ifetch_responder_if.sv | 47 ++++
 rtl/ifetch_responder_sync_fifo.sv | 84 ++++++++
 rtl/ifetch_responder.sv | 159 +++++++++++++++
 tb/tb_ifetch_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_responder_pkg.sv
// ifetch_responder_pkg
//   Types and helpers shared by the instruction-fetch responder and its
//   response queue.
//   - NUM_WRAPS_PER_CORE : warps per core (sets the warp-id width)
//   - scalar_t           : 32-bit machine word
//   - warp_id_t          : warp index
//   - ifetch_resp_t      : one queued response {warp, pc, inst, fault, killed}
//   - pc_fault()         : misaligned / out-of-range PC test
package ifetch_responder_pkg;

  localparam int NUM_WRAPS_PER_CORE = 4;
  localparam int WARP_W = $clog2(NUM_WRAPS_PER_CORE);

  typedef logic [31:0]       scalar_t;
  typedef logic [WARP_W-1:0] warp_id_t;

  // killed is the LSB so the parent can patch it in place in the queue.
  typedef struct packed {
    warp_id_t warp;
    scalar_t  pc;
    scalar_t  inst;
    logic     fault;
    logic     killed;
  } ifetch_resp_t;

  localparam int RESP_W = $bits(ifetch_resp_t);

  // A PC faults when it is not word aligned or its word index lies past the
  // end of the instruction SRAM.
  function automatic logic pc_fault(input scalar_t pc, input int unsigned words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= words);
  endfunction

endpackage

// File: rtl/ifetch_responder_if.sv
// ifetch_responder_if
//   Fetch-stage <-> responder bus.
//   master : warp fetch stage / loader (drives requests, flush, SRAM writes,
//            resp_ready)
//   slave  : ifetch_responder (drives req_ready and the response channel)
//   Signals: req_valid/req_ready/req_warp/req_pc, resp_valid/resp_ready/
//            resp_warp/resp_pc/resp_inst/resp_fault, flush_valid/flush_warp,
//            imem_we/imem_waddr/imem_wdata.
interface ifetch_responder_if #(
  parameter int IMEM_AW = 10
);
  import ifetch_responder_pkg::*;

  logic               req_valid;
  logic               req_ready;
  warp_id_t           req_warp;
  scalar_t            req_pc;

  logic               resp_valid;
  logic               resp_ready;
  warp_id_t           resp_warp;
  scalar_t            resp_pc;
  scalar_t            resp_inst;
  logic               resp_fault;

  logic               flush_valid;
  warp_id_t           flush_warp;

  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  scalar_t            imem_wdata;

  modport master (
    output req_valid, req_warp, req_pc, resp_ready,
    output flush_valid, flush_warp,
    output imem_we, imem_waddr, imem_wdata,
    input  req_ready, resp_valid, resp_warp, resp_pc, resp_inst, resp_fault
  );

  modport slave (
    input  req_valid, req_warp, req_pc, resp_ready,
    input  flush_valid, flush_warp,
    input  imem_we, imem_waddr, imem_wdata,
    output req_ready, resp_valid, resp_warp, resp_pc, resp_inst, resp_fault
  );

endinterface

// File: rtl/ifetch_responder_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO whose storage is visible and patchable in place.
//   clk, reset     : clock, asynchronous active-high reset (control only)
//   push/push_data : write an entry (ignored when full)
//   pop            : drop the head (ignored when empty)
//   rd_data        : head entry
//   count/full/empty
//   mem_flat       : all slots, slot i at [i*WIDTH +: WIDTH]
//   slot_vld       : which slots currently hold a queued entry
//   upd_en/upd_flat: overwrite slot i with upd_flat[i*WIDTH +: WIDTH]
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH*WIDTH-1:0] mem_flat,
  output logic [DEPTH-1:0]       slot_vld,
  input  logic [DEPTH-1:0]       upd_en,
  input  logic [DEPTH*WIDTH-1:0] upd_flat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_flat[i*WIDTH +: WIDTH] = mem[i];
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr           <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        slot_vld[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr           <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        slot_vld[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pushed slot is never a valid slot, so push and in-place updates never
  // target the same entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (upd_en[i]) mem[i] <= upd_flat[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/ifetch_responder.sv
// ifetch_responder
//   Responder end of the per-core instruction fetch interface. Accepts
//   {warp, PC} requests, reads a word-addressed instruction SRAM and returns
//   responses in acceptance order through a response FIFO. A per-warp flush
//   kills every queued or in-flight response of that warp; killed entries are
//   dropped silently at the queue head. SRAM contents are written by a
//   separate loader port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ifetch_responder_if.slave (request, response, flush, SRAM write)
module ifetch_responder
  import ifetch_responder_pkg::*;
#(
  parameter int NUM_WARPS  = 4,
  parameter int IMEM_WORDS = 1024,
  parameter int RESP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_responder_if.slave   bus
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

  if (NUM_WARPS != NUM_WRAPS_PER_CORE) begin : g_bad_warps
    $error("ifetch_responder: NUM_WARPS must equal NUM_WRAPS_PER_CORE");
  end
  if (RESP_DEPTH < 2) begin : g_bad_depth
    $error("ifetch_responder: RESP_DEPTH must be at least 2");
  end

  logic                         accept;
  logic [CNT_W-1:0]             outstanding;

  scalar_t                      imem [IMEM_WORDS];
  scalar_t                      inst_p1;
  logic                         vld_p1;
  warp_id_t                     warp_p1;
  scalar_t                      pc_p1;
  logic                         fault_p1;

  ifetch_resp_t                 push_entry;
  ifetch_resp_t                 head;
  logic [RESP_W-1:0]            fifo_rd;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [RESP_DEPTH*RESP_W-1:0] fifo_mem;
  logic [RESP_DEPTH-1:0]        slot_vld;
  logic [RESP_DEPTH-1:0]        upd_en;
  logic [RESP_DEPTH*RESP_W-1:0] upd_flat;
  logic                         head_vld;
  logic                         pop;

  // ---- stage A: request accept, SRAM read issue ----
  // Ready comes from registered state only, never from req_valid.
  assign bus.req_ready = (outstanding < CNT_W'(RESP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;

  // Read-first: the read sees the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
    if (accept)      inst_p1 <= imem[bus.req_pc[2 +: IMEM_AW]];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      warp_p1  <= bus.req_warp;
      pc_p1    <= bus.req_pc;
      fault_p1 <= pc_fault(bus.req_pc, IMEM_WORDS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= accept;
  end

  // ---- stage B: SRAM data valid, enqueue response ----
  // A request accepted alongside a flush is the redirected fetch and lives;
  // the one already in stage B is killed on its way into the queue.
  always_comb begin
    push_entry.warp   = warp_p1;
    push_entry.pc     = pc_p1;
    push_entry.inst   = fault_p1 ? '0 : inst_p1;
    push_entry.fault  = fault_p1;
    push_entry.killed = bus.flush_valid && (warp_p1 == bus.flush_warp);
  end

  always_comb begin
    ifetch_resp_t e;
    e        = '0;
    upd_en   = '0;
    upd_flat = fifo_mem;
    for (int i = 0; i < RESP_DEPTH; i++) begin
      e = fifo_mem[i*RESP_W +: RESP_W];
      if (bus.flush_valid && slot_vld[i] && (e.warp == bus.flush_warp)) begin
        e.killed                   = 1'b1;
        upd_en[i]                  = 1'b1;
        upd_flat[i*RESP_W +: RESP_W] = e;
      end
    end
  end

  sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (push_entry),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .mem_flat  (fifo_mem),
    .slot_vld  (slot_vld),
    .upd_en    (upd_en),
    .upd_flat  (upd_flat)
  );

  // ---- response: FIFO head drives the output channel ----
  // A flush that lands while the head handshakes does not recall it: the
  // kill bit only takes effect from the next cycle.
  assign head     = fifo_rd;
  assign head_vld = !fifo_empty;
  assign pop      = head_vld && (head.killed || bus.resp_ready);

  assign bus.resp_valid = head_vld && !head.killed;
  assign bus.resp_warp  = bus.resp_valid ? head.warp  : '0;
  assign bus.resp_pc    = bus.resp_valid ? head.pc    : '0;
  assign bus.resp_inst  = bus.resp_valid ? head.inst  : '0;
  assign bus.resp_fault = bus.resp_valid && head.fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (reset) !(vld_p1 && fifo_full));

  a_credit_matches : assert property (
    @(posedge clk) disable iff (reset)
      outstanding == fifo_count + CNT_W'(vld_p1));

  a_credit_bound : assert property (
    @(posedge clk) disable iff (reset) outstanding <= CNT_W'(RESP_DEPTH));

endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder
//   Directed bench for ifetch_responder: reset values, fetch latency,
//   credit back-pressure, ordering, fault detection, per-warp flush,
//   SRAM read-first behaviour and mid-operation reset.
module tb_ifetch_responder;
  import ifetch_responder_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   stale;

  ifetch_responder_if #(.IMEM_AW(10)) bus ();

  ifetch_responder #(
    .NUM_WARPS  (4),
    .IMEM_WORDS (1024),
    .RESP_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic imem_write(input logic [9:0] addr, input logic [31:0] data);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = addr;
    bus.imem_wdata = data;
    tick();
    bus.imem_we    = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] warp, input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_warp  = warp;
    bus.req_pc    = pc;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    stale = 0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_warp    = '0;
    bus.req_pc      = '0;
    bus.resp_ready  = 1'b0;
    bus.flush_valid = 1'b0;
    bus.flush_warp  = '0;
    bus.imem_we     = 1'b0;
    bus.imem_waddr  = '0;
    bus.imem_wdata  = '0;

    tick();
    tick();
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready",  bus.req_ready,  1);
    check("rst_resp_warp",  bus.resp_warp,  0);
    check("rst_resp_pc",    bus.resp_pc,    0);
    check("rst_resp_inst",  bus.resp_inst,  0);
    check("rst_resp_fault", bus.resp_fault, 0);
    reset = 1'b0;
    tick();

    imem_write(10'd0, 32'h11);
    imem_write(10'd1, 32'h22);
    imem_write(10'd2, 32'h33);
    imem_write(10'd3, 32'h44);
    imem_write(10'd5, 32'h55);

    // Single fetch: accept in cycle N, response visible in cycle N+2.
    bus.resp_ready = 1'b1;
    drive_req(2'd1, 32'h8);
    check("t1_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("t1_n1_valid", bus.resp_valid, 0);
    tick();
    check("t1_valid", bus.resp_valid, 1);
    check("t1_warp",  bus.resp_warp,  1);
    check("t1_pc",    bus.resp_pc,    32'h8);
    check("t1_inst",  bus.resp_inst,  32'h33);
    check("t1_fault", bus.resp_fault, 0);
    tick();
    check("t1_drained", bus.resp_valid, 0);

    // Back-to-back fill until the credit runs out.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(2'(i), 32'(4 * i));
      tick();
    end
    bus.req_valid = 1'b0;
    check("t2_ready_low", bus.req_ready, 0);
    tick();
    check("t2_ready_still_low", bus.req_ready, 0);
    check("t2_head_valid", bus.resp_valid, 1);
    bus.resp_ready = 1'b1;
    check("t2_inst0", bus.resp_inst, 32'h11);
    check("t2_warp0", bus.resp_warp, 0);
    tick();
    check("t2_ready_back", bus.req_ready, 1);
    check("t2_inst1", bus.resp_inst, 32'h22);
    check("t2_warp1", bus.resp_warp, 1);
    tick();
    check("t2_inst2", bus.resp_inst, 32'h33);
    tick();
    check("t2_inst3", bus.resp_inst, 32'h44);
    check("t2_warp3", bus.resp_warp, 3);
    check("t2_valid3", bus.resp_valid, 1);
    tick();
    check("t2_empty", bus.resp_valid, 0);

    // Faulting PCs: misaligned, then one word past the end of the SRAM.
    drive_req(2'd0, 32'h6);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t3a_valid", bus.resp_valid, 1);
    check("t3a_fault", bus.resp_fault, 1);
    check("t3a_inst",  bus.resp_inst,  0);
    check("t3a_pc",    bus.resp_pc,    32'h6);
    tick();
    drive_req(2'd3, 32'h1000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t3b_valid", bus.resp_valid, 1);
    check("t3b_fault", bus.resp_fault, 1);
    check("t3b_inst",  bus.resp_inst,  0);
    check("t3b_warp",  bus.resp_warp,  3);
    tick();

    // Flush warp 2 while its redirected fetch is accepted in the same cycle.
    bus.resp_ready = 1'b0;
    drive_req(2'd2, 32'h0);
    tick();
    drive_req(2'd0, 32'h4);
    tick();
    drive_req(2'd2, 32'h8);
    tick();
    drive_req(2'd2, 32'hC);
    bus.flush_valid = 1'b1;
    bus.flush_warp  = 2'd2;
    tick();
    bus.req_valid   = 1'b0;
    bus.flush_valid = 1'b0;
    check("t4_killed_head", bus.resp_valid, 0);
    tick();
    check("t4_w0_valid", bus.resp_valid, 1);
    check("t4_w0_pc",    bus.resp_pc,    32'h4);
    check("t4_w0_warp",  bus.resp_warp,  0);
    tick();
    check("t4_w0_hold_pc",  bus.resp_pc,   32'h4);
    check("t4_w0_hold_ins", bus.resp_inst, 32'h22);
    bus.resp_ready = 1'b1;
    tick();
    check("t4_killed_mid", bus.resp_valid, 0);
    tick();
    check("t4_redir_valid", bus.resp_valid, 1);
    check("t4_redir_pc",    bus.resp_pc,    32'hC);
    check("t4_redir_warp",  bus.resp_warp,  2);
    check("t4_redir_inst",  bus.resp_inst,  32'h44);
    tick();
    check("t4_empty",       bus.resp_valid, 0);
    check("t4_outstanding", 32'(dut.outstanding), 0);

    // Same-cycle SRAM write and read of word 5 returns the old contents.
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 10'd5;
    bus.imem_wdata = 32'hAA;
    drive_req(2'd1, 32'h14);
    tick();
    bus.imem_we   = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    check("t5_old_data", bus.resp_inst, 32'h55);
    tick();
    drive_req(2'd1, 32'h14);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t5_new_data", bus.resp_inst, 32'hAA);
    tick();

    // Reset with three requests outstanding.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(2'(i), 32'(4 * i));
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    check("t6_pre_valid", bus.resp_valid, 1);
    check("t6_pre_ready", bus.req_ready,  1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", bus.resp_valid, 0);
    check("t6_async_ready", bus.req_ready,  1);
    check("t6_async_inst",  bus.resp_inst,  0);
    tick();
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.resp_valid) stale++;
    end
    check("t6_no_stale", 32'(stale), 0);
    check("t6_ready",    bus.req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
